// File: rtl/minmax_pkg.sv
// Shared FSM encoding and width helpers for the min/max tracker.
// Pure declarations: no latency, no flow control.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n_samples);
    return $clog2(n_samples);
  endfunction

  function automatic int cnt_w(input int n_samples);
    return $clog2(n_samples + 1);
  endfunction

endpackage

// File: rtl/mag_cmp.sv
// Unsigned WIDTH-bit magnitude compare; exactly one of eq/gt/lt is high.
// Purely combinational, zero latency, no flow control.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Tracks running max/min and first-occurrence indices over N_SAMPLES accepted samples.
// Results visible one cycle after each accept; in_ready is high only while running (no skid).
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int N_SAMPLES = 8,
  localparam int IW = idx_w(N_SAMPLES),
  localparam int CW = cnt_w(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IW-1:0]    max_idx,
  output logic [IW-1:0]    min_idx,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_d;

  logic accept;
  logic launch;
  logic last_accept;
  logic max_eq, max_gt, max_lt;
  logic min_eq, min_gt, min_lt;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (max_val),
    .eq (max_eq),
    .gt (max_gt),
    .lt (max_lt)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (min_val),
    .eq (min_eq),
    .gt (min_gt),
    .lt (min_lt)
  );

  assign in_ready    = (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign accept      = in_valid & in_ready;
  assign launch      = start & ((state_q == IDLE) | (state_q == DONE));
  assign last_accept = accept & (count == CW'(N_SAMPLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_accept) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Equal samples never update, so ties keep the earliest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      min_idx <= '0;
      count   <= '0;
    end else if (launch) begin
      max_idx <= '0;
      min_idx <= '0;
      count   <= '0;
    end else if (accept) begin
      count <= count + CW'(1);
      if (count == '0) begin
        max_val <= in_data;
        min_val <= in_data;
        max_idx <= '0;
        min_idx <= '0;
      end else begin
        if (max_gt) begin
          max_val <= in_data;
          max_idx <= count[IW-1:0];
        end
        if (min_lt) begin
          min_val <= in_data;
          min_idx <= count[IW-1:0];
        end
      end
    end
  end

endmodule
